// File: rtl/csa_top.sv
// Registered 4:2 carry-save compressor that reduces four operands and two carry-ins
// to a sum/carry pair. It is used to hold the online-multiplier residual in redundant form.

module csa_fa (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ z;
    assign co = (x & y) | (x & z) | (y & z);
endmodule

// Top-bit cell. The carry out of the MSB has no weight inside the word, so only the sum is built.
module csa_xor3 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s
);
    assign s = x ^ y ^ z;
endmodule

module csa_top #(
    parameter int Stage = 3,
    parameter int WL    = Stage
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    input  logic [WL-1:0] c,
    input  logic [WL-1:0] d,
    input  logic          cin1,
    input  logic          cin2,
    output logic [WL-1:0] Ws,
    output logic [WL-1:0] Wc
);
    logic [WL-1:0] s1;
    logic [WL-1:0] t;
    logic [WL-1:0] ws_n;
    logic [WL-1:0] wc_n;

    assign t[0]    = cin1;
    assign wc_n[0] = cin2;

    // Each carry feeds the next bit position directly, which performs the one-bit shift in place.
    for (genvar i = 0; i < WL; i++) begin : g_bit
        if (i < WL - 1) begin : g_full
            csa_fa u_l1 (.x(a[i]),  .y(b[i]), .z(c[i]), .s(s1[i]),   .co(t[i+1]));
            csa_fa u_l2 (.x(s1[i]), .y(d[i]), .z(t[i]), .s(ws_n[i]), .co(wc_n[i+1]));
        end else begin : g_msb
            csa_xor3 u_l1 (.x(a[i]),  .y(b[i]), .z(c[i]), .s(s1[i]));
            csa_xor3 u_l2 (.x(s1[i]), .y(d[i]), .z(t[i]), .s(ws_n[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            Ws <= '0;
            Wc <= '0;
        end else begin
            Ws <= ws_n;
            Wc <= wc_n;
        end
    end
endmodule

// File: tb/tb_csa_top.sv
// Bench for csa_top at WL=3. It applies directed table vectors, an exhaustive sweep
// and a mid-stream reset sequence.

module tb_csa_top;
    localparam int WL = 3;

    logic          clk;
    logic          nReset;
    logic [WL-1:0] a, b, c, d;
    logic          cin1, cin2;
    logic [WL-1:0] Ws, Wc;

    int n_checks = 0;
    int n_fail   = 0;

    csa_top #(.Stage(3), .WL(WL)) dut (
        .clk(clk), .nReset(nReset),
        .a(a), .b(b), .c(c), .d(d),
        .cin1(cin1), .cin2(cin2),
        .Ws(Ws), .Wc(Wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [WL-1:0] a, b, c, d;
        logic          cin1, cin2;
        logic [WL-1:0] ws, wc;
    } vec_t;

    task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference reduction written from the bit equations, with the two carry rows built as vectors.
    task automatic model(input logic [WL-1:0] ia, ib, ic, id, input logic ic1, ic2,
                         output logic [WL-1:0] ews, output logic [WL-1:0] ewc);
        logic [WL-1:0] s1, k1, tt, k2;
        s1  = ia ^ ib ^ ic;
        k1  = (ia & ib) | (ia & ic) | (ib & ic);
        tt  = {k1[WL-2:0], ic1};
        ews = s1 ^ id ^ tt;
        k2  = (s1 & id) | (s1 & tt) | (id & tt);
        ewc = {k2[WL-2:0], ic2};
    endtask

    task automatic drive(input logic r, input logic [WL-1:0] ia, ib, ic, id, input logic ic1, ic2);
        @(negedge clk);
        nReset = r; a = ia; b = ib; c = ic; d = id; cin1 = ic1; cin2 = ic2;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        logic [WL-1:0] ews, ewc, esum, asum;
        logic [13:0]   bits;

        nReset = 1'b1; a = '0; b = '0; c = '0; d = '0; cin1 = 1'b0; cin2 = 1'b0;

        vecs[0] = '{1'b1, 3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 3'b000};
        vecs[1] = '{1'b1, 3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 3'b000, 3'b000};
        vecs[2] = '{1'b0, 3'b000, 3'b001, 3'b110, 3'b110, 1'b1, 1'b1, 3'b000, 3'b111};
        vecs[3] = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111, 3'b111};
        vecs[4] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000};
        vecs[5] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 3'b001};
        vecs[6] = '{1'b0, 3'b001, 3'b010, 3'b100, 3'b000, 1'b0, 1'b0, 3'b111, 3'b000};
        vecs[7] = '{1'b0, 3'b011, 3'b011, 3'b000, 3'b001, 1'b0, 1'b1, 3'b111, 3'b001};
        vecs[8] = '{1'b1, 3'b011, 3'b011, 3'b000, 3'b001, 1'b0, 1'b1, 3'b000, 3'b000};
        vecs[9] = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 3'b111, 3'b111};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].cin1, vecs[i].cin2);
            check($sformatf("vec%0d_ws", i), Ws, vecs[i].ws);
            check($sformatf("vec%0d_wc", i), Wc, vecs[i].wc);
        end

        for (int v = 0; v < 16384; v++) begin
            bits = v[13:0];
            drive(1'b0, bits[2:0], bits[5:3], bits[8:6], bits[11:9], bits[12], bits[13]);
            model(bits[2:0], bits[5:3], bits[8:6], bits[11:9], bits[12], bits[13], ews, ewc);
            esum = bits[2:0] + bits[5:3] + bits[8:6] + bits[11:9] + {2'b00, bits[12]} + {2'b00, bits[13]};
            asum = Ws + Wc;
            check($sformatf("sweep%0d_sum", v), asum, esum);
            check($sformatf("sweep%0d_wc0", v), {2'b00, Wc[0]}, {2'b00, bits[13]});
            check($sformatf("sweep%0d_ws", v), Ws, ews);
            check($sformatf("sweep%0d_wc", v), Wc, ewc);
        end

        for (int k = 0; k < 20; k++) begin
            logic          r;
            logic [WL-1:0] ra, rb, rc, rd;
            logic          r1, r2;
            r  = (k == 10);
            ra = WL'($urandom_range(7)); rb = WL'($urandom_range(7));
            rc = WL'($urandom_range(7)); rd = WL'($urandom_range(7));
            r1 = 1'($urandom_range(1));  r2 = 1'($urandom_range(1));
            drive(r, ra, rb, rc, rd, r1, r2);
            if (r) begin
                ews = '0;
                ewc = '0;
            end else begin
                model(ra, rb, rc, rd, r1, r2, ews, ewc);
            end
            check($sformatf("midrst%0d_ws", k), Ws, ews);
            check($sformatf("midrst%0d_wc", k), Wc, ewc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_top.md
Name: csa_top

Overview:
- Registered 4-operand carry-save adder (4:2 compressor) with two injected carry-in bits.
- Reduces four WL-bit operands plus cin1 and cin2 to a redundant sum/carry pair (Ws, Wc).
- Building block for the online-multiplier recurrence, where the residual is kept in carry-save form.
- The pair is captured in output registers each clock.

Parameters:
- Stage, 3, number of digit stages in the recurrence.
- WL, Stage, word length of every operand and output vector.

Ports:
- clk  input  1  rising-edge clock.
- nReset  input  1  reset; synchronous, active-high despite its name. nReset=1 at a rising clk edge resets the block.
- a  input  WL  operand 1.
- b  input  WL  operand 2.
- c  input  WL  operand 3.
- d  input  WL  operand 4.
- cin1  input  1  carry injected into bit 0 of the first-level carry vector.
- cin2  input  1  carry injected into bit 0 of the output carry vector.
- Ws  output  WL  registered sum vector.
- Wc  output  WL  registered carry vector, already aligned to the weight of Ws.

Behaviour:
- Level 1, bitwise full adders for i=0..WL-1:
  - s1[i] = a[i]^b[i]^c[i]
  - k1[i] = maj(a[i],b[i],c[i])
- Shifted carry vector:
  - t[0] = cin1
  - t[i] = k1[i-1] for i>=1
  - k1[WL-1] is discarded.
- Level 2, bitwise full adders:
  - ws_n[i] = s1[i]^d[i]^t[i]
  - k2[i] = maj(s1[i],d[i],t[i])
- Next carry vector:
  - wc_n[0] = cin2
  - wc_n[i] = k2[i-1] for i>=1
  - k2[WL-1] is discarded.
- Invariant: (ws_n + wc_n) mod 2^WL == (a+b+c+d+cin1+cin2) mod 2^WL. All arithmetic is unsigned modulo 2^WL and carries beyond bit WL-1 are dropped. Two's-complement interpretation is therefore also preserved.
- Datapath is purely combinational up to the output registers. Full adders are structural cells, one per bit per level, instantiated by generate for any WL>=1.
- Register, on each rising clk:
  - If nReset==1: Ws<=0 and Wc<=0.
  - Else: Ws<=ws_n and Wc<=wc_n.
- Latency is 1 cycle. Inputs sampled at edge N appear on Ws/Wc after edge N and hold until edge N+1. Throughput is one result per cycle.
- No handshake; the block is always enabled.
- Reset takes priority over data at the same edge.
- Reset asserted mid-stream clears the outputs at the next edge. The first valid result appears one edge after nReset returns to 0.
- Before the first clk edge the outputs are unspecified; the bench must apply reset first.
- No internal state other than the 2*WL output flops.

Test Plan:
- Reset: nReset=1 for 2 edges with a=b=c=d=111, cin1=cin2=1 -> Ws=000, Wc=000.
- Mixed operands: nReset=0, a=000, b=001, c=110, d=110, cin1=1, cin2=1 -> after one edge Ws=000, Wc=111 (sum 7 = 15 mod 8).
- Saturation: a=b=c=d=111, cin1=cin2=1 -> Ws=111, Wc=111 (14 mod 8 = 6 = 30 mod 8). Confirms carries out of the MSB are dropped.
- Carry-in paths:
  - All operands 0, cin1=1, cin2=0 -> Ws=001, Wc=000.
  - All operands 0, cin1=0, cin2=1 -> Ws=000, Wc=001.
- Exhaustive, WL=3: sweep all 2^14 input combinations, one per cycle. Check (Ws+Wc) mod 8 == (a+b+c+d+cin1+cin2) mod 8 one cycle later. Check Wc[0] == registered cin2.
- Mid-stream reset: stream random vectors, assert nReset=1 for one edge -> outputs 0 the next cycle. Correct 1-cycle-latency results resume after release.
